// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a 64-word, registered-read data memory.
// Sub-word stores run read-modify-write; every output is decoded from state and latched registers.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        WE_mem2,
  output logic        RE_mem2,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_CAP, WR, RMW_RD, RMW_MERGE, RMW_WR, RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        we_q, we_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;

  logic        accept, req_err;
  logic [4:0]  lane_shift;
  logic [31:0] lane_data, load_val, lane_mask, merged;

  assign accept = (state_q == IDLE) && req_valid;

  // Misalignment, out-of-range (beyond 256 bytes) and the reserved size all fail.
  assign req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || (req_addr[31:8] != 24'd0);

  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane_data  = mem_rdata >> lane_shift;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    load_val  = mem_rdata;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      SZ_BYTE: begin
        load_val  = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
        lane_mask = 32'h0000_00FF << lane_shift;
      end
      SZ_HALF: begin
        load_val  = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
        lane_mask = 32'h0000_FFFF << lane_shift;
      end
      default: ;
    endcase
    merged = (mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                state_d = RESP;
          else if (!req_we)           state_d = RD;
          else if (req_size == SZ_WORD) state_d = WR;
          else                        state_d = RMW_RD;
        end
      end
      RD:        state_d = RD_CAP;
      RD_CAP:    state_d = RESP;
      WR:        state_d = RESP;
      RMW_RD:    state_d = RMW_MERGE;
      RMW_MERGE: state_d = RMW_WR;
      RMW_WR:    state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Request latch and data word: captured load lane or merged store word.
  always_comb begin
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    data_d   = data_q;
    if (accept) begin
      we_d     = req_we;
      size_d   = req_size;
      signed_d = req_signed;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      err_d    = req_err;
      data_d   = 32'd0;
    end else if (state_q == RD_CAP) begin
      data_d = load_val;
    end else if (state_q == RMW_MERGE) begin
      data_d = merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  // Moore outputs; reset forces IDLE so enables drop asynchronously.
  always_comb begin
    req_ready  = (state_q == IDLE);
    RE_mem2    = (state_q == RD) || (state_q == RMW_RD);
    WE_mem2    = (state_q == WR) || (state_q == RMW_WR);
    mem_addr   = (state_q != IDLE) ? {2'b00, addr_q[31:2]} : 32'd0;
    mem_wdata  = 32'd0;
    if (state_q == WR)     mem_wdata = wdata_q;
    if (state_q == RMW_WR) mem_wdata = data_q;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = (state_q == RESP && !we_q) ? data_q : 32'd0;
  end

endmodule
